// File: rtl/timer_apb_seq.sv
// -----------------------------------------------------------------------------
// timer_apb_seq
//
// APB master that programs and services an 8-bit timer (TDR/TCR/TSR) without
// CPU involvement.
//
// Sequence: load TDR, pulse the TCR load bit, start the count, then poll TSR
// every POLL_GAP cycles. Each detected overflow/underflow flag is cleared
// with a TSR write and reported as a one-cycle tick.
//
// Ports:
//   pclk, presetn        clock, asynchronous active-low reset
//   start, stop          control pulses (start only honoured in IDLE)
//   one_shot, cfg_*      run configuration, captured when start is accepted
//   psel..pwdata         APB master request outputs (registered)
//   prdata, pready,
//   pslverr              APB slave response inputs
//   busy                 FSM is not in IDLE
//   tick                 one-cycle pulse per serviced timer event
//   evt_cnt              serviced events since the last accepted start
//   err                  sticky error (slave error or pready timeout)
//   dbg_state            current FSM state encoding, for observation only
//
// APB handshake: a transfer is one SETUP cycle (psel=1, penable=0) followed
// by ACCESS cycles (psel=1, penable=1) until pready=1 is sampled on a rising
// edge; that edge completes the transfer. paddr/pwdata/pwrite are loaded at
// SETUP and held until completion. psel is low for at least one cycle
// between transfers, so there are never back-to-back transfers.
// -----------------------------------------------------------------------------
module timer_apb_seq #(
  parameter logic [7:0]  ADDR_TDR   = 8'h00,
  parameter logic [7:0]  ADDR_TCR   = 8'h01,
  parameter logic [7:0]  ADDR_TSR   = 8'h02,
  parameter int unsigned POLL_GAP   = 16,
  parameter int unsigned PREADY_TMO = 64
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       start,
  input  logic       stop,
  input  logic       one_shot,
  input  logic [7:0] cfg_tdr,
  input  logic       cfg_dw,
  input  logic [1:0] cfg_clk_sel,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic [7:0] paddr,
  output logic [7:0] pwdata,
  input  logic [7:0] prdata,
  input  logic       pready,
  input  logic       pslverr,
  output logic       busy,
  output logic       tick,
  output logic [7:0] evt_cnt,
  output logic       err,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_W_TDR  = 3'd1,
    S_W_LOAD = 3'd2,
    S_W_RUN  = 3'd3,
    S_GAP    = 3'd4,
    S_R_TSR  = 3'd5,
    S_W_CLR  = 3'd6,
    S_W_STOP = 3'd7
  } state_t;

  // Bus phase inside a transfer state. PH_IDLE is the mandatory psel=0
  // cycle before SETUP.
  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_ACCESS = 2'd2
  } phase_t;

  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);
  localparam logic [15:0] TMO_LAST = 16'(PREADY_TMO - 1);

  state_t      state;
  phase_t      phase;
  logic [7:0]  tdr_q;
  logic        dw_q;
  logic [1:0]  clk_sel_q;
  logic        one_shot_q;
  logic        stop_pend;
  logic [15:0] gap_cnt;
  logic [15:0] tmo_cnt;

  logic [7:0]  op_addr;
  logic [7:0]  op_data;
  logic        op_write;
  logic        flag;
  logic        stop_now;
  logic        unused_prdata;

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;
  assign flag      = dw_q ? prdata[1] : prdata[0];
  assign stop_now  = stop | stop_pend;
  // Only the two flag bits of TSR are of interest.
  assign unused_prdata = ^prdata[7:2];

  // Request issued by each transfer state.
  always_comb begin
    op_addr  = ADDR_TDR;
    op_data  = 8'h00;
    op_write = 1'b1;
    unique case (state)
      S_W_TDR:  begin op_addr = ADDR_TDR; op_data = tdr_q; end
      S_W_LOAD: begin op_addr = ADDR_TCR; op_data = 8'h80; end
      S_W_RUN:  begin
        op_addr = ADDR_TCR;
        op_data = {2'b00, dw_q, 1'b1, 2'b00, clk_sel_q};
      end
      S_R_TSR:  begin op_addr = ADDR_TSR; op_write = 1'b0; end
      S_W_CLR:  op_addr = ADDR_TSR;
      S_W_STOP: op_addr = ADDR_TCR;
      default:  op_addr = ADDR_TDR;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state      <= S_IDLE;
      phase      <= PH_IDLE;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= 8'h00;
      pwdata     <= 8'h00;
      tick       <= 1'b0;
      err        <= 1'b0;
      evt_cnt    <= 8'h00;
      tdr_q      <= 8'h00;
      dw_q       <= 1'b0;
      clk_sel_q  <= 2'b00;
      one_shot_q <= 1'b0;
      stop_pend  <= 1'b0;
      gap_cnt    <= 16'h0;
      tmo_cnt    <= 16'h0;
    end else begin
      tick <= 1'b0;
      unique case (state)
        S_IDLE: begin
          stop_pend <= 1'b0;
          if (start) begin
            tdr_q      <= cfg_tdr;
            dw_q       <= cfg_dw;
            clk_sel_q  <= cfg_clk_sel;
            one_shot_q <= one_shot;
            err        <= 1'b0;
            evt_cnt    <= 8'h00;
            state      <= S_W_TDR;
            phase      <= PH_IDLE;
          end
        end

        S_GAP: begin
          if (stop) begin
            state     <= S_W_STOP;
            phase     <= PH_IDLE;
            stop_pend <= 1'b0;
          end else if (gap_cnt == GAP_LAST) begin
            // The gap itself is the bus-idle time, so the read launches
            // straight into SETUP.
            state   <= S_R_TSR;
            phase   <= PH_SETUP;
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= ADDR_TSR;
            pwdata  <= 8'h00;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end

        default: begin
          // A stop during a transfer is held until that transfer completes.
          if (stop && state != S_W_STOP) stop_pend <= 1'b1;
          unique case (phase)
            PH_IDLE: begin
              psel    <= 1'b1;
              penable <= 1'b0;
              paddr   <= op_addr;
              pwdata  <= op_data;
              pwrite  <= op_write;
              phase   <= PH_SETUP;
            end
            PH_SETUP: begin
              penable <= 1'b1;
              tmo_cnt <= 16'h0;
              phase   <= PH_ACCESS;
            end
            default: begin
              if (pready) begin
                psel      <= 1'b0;
                penable   <= 1'b0;
                phase     <= PH_IDLE;
                gap_cnt   <= 16'h0;
                stop_pend <= 1'b0;
                if (pslverr) begin
                  err   <= 1'b1;
                  state <= S_IDLE;
                end else begin
                  unique case (state)
                    S_W_TDR:  state <= stop_now ? S_W_STOP : S_W_LOAD;
                    S_W_LOAD: state <= stop_now ? S_W_STOP : S_W_RUN;
                    S_W_RUN:  state <= stop_now ? S_W_STOP : S_GAP;
                    S_R_TSR: begin
                      if (flag) begin
                        // A pending stop survives so the flag is still cleared.
                        state     <= S_W_CLR;
                        stop_pend <= stop_now;
                      end else begin
                        state <= stop_now ? S_W_STOP : S_GAP;
                      end
                    end
                    S_W_CLR: begin
                      tick    <= 1'b1;
                      evt_cnt <= evt_cnt + 8'd1;
                      state   <= (one_shot_q || stop_now) ? S_W_STOP : S_GAP;
                    end
                    default:  state <= S_IDLE;
                  endcase
                end
              end else if (tmo_cnt == TMO_LAST) begin
                psel      <= 1'b0;
                penable   <= 1'b0;
                phase     <= PH_IDLE;
                stop_pend <= 1'b0;
                err       <= 1'b1;
                state     <= S_IDLE;
              end else begin
                tmo_cnt <= tmo_cnt + 16'd1;
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_apb_seq.sv
// -----------------------------------------------------------------------------
// tb_timer_apb_seq
//
// Drives timer_apb_seq against a behavioural APB slave / timer model. The
// expected APB transaction list for each run is derived from the programming
// sequence (TDR, TCR load, TCR run, polled TSR reads, clears, TCR stop) and
// compared with the transactions observed on the bus.
// -----------------------------------------------------------------------------
module tb_timer_apb_seq;

  localparam logic [7:0] A_TDR = 8'h00;
  localparam logic [7:0] A_TCR = 8'h01;
  localparam logic [7:0] A_TSR = 8'h02;
  localparam int         GAP   = 16;
  localparam int         TMO   = 64;
  localparam int         W     = 17;  // {write, addr, data}

  // ---------------------------------------------------------------- clock/reset
  logic pclk    = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  // ---------------------------------------------------------------- DUT
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       one_shot = 1'b0;
  logic [7:0] cfg_tdr = 8'h00;
  logic       cfg_dw = 1'b0;
  logic [1:0] cfg_clk_sel = 2'b00;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic [7:0] prdata = 8'h00;
  logic       pready = 1'b0;
  logic       pslverr = 1'b0;
  logic       busy, tick, err;
  logic [7:0] evt_cnt;
  logic [2:0] dbg_state;

  timer_apb_seq dut (
    .pclk(pclk), .presetn(presetn), .start(start), .stop(stop),
    .one_shot(one_shot), .cfg_tdr(cfg_tdr), .cfg_dw(cfg_dw),
    .cfg_clk_sel(cfg_clk_sel), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .busy(busy), .tick(tick),
    .evt_cnt(evt_cnt), .err(err), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [7:0]   resp_q[$];
  logic [7:0]   tsr_q[$];
  int           exp_ticks;
  int           n_before_stop;
  int           n_checks = 0;
  int           n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------------------------------------------------------- slave + monitor
  int wait_states = 0;
  int slverr_idx  = -1;
  int xfer_idx, setups, acc_cycles, tick_cnt;
  int proto_viol, gap_viol, tick_viol;
  int idle_run, since_done;
  bit prev_psel, prev_setup, prev_tick, last_was_clr;
  logic       cur_w;
  logic [7:0] cur_a, cur_d;

  always @(negedge pclk) begin
    if (!presetn) begin
      prev_psel  = 1'b0;
      prev_setup = 1'b0;
      prev_tick  = 1'b0;
      idle_run   = 0;
      pready     = 1'b0;
      pslverr    = 1'b0;
    end else begin
      since_done++;
      if (tick) begin
        tick_cnt++;
        if (prev_tick || since_done != 1 || !last_was_clr) tick_viol++;
      end
      prev_tick = tick;
      pready  = 1'b0;
      pslverr = 1'b0;
      if (prev_setup && !(psel && penable)) proto_viol++;
      prev_setup = 1'b0;
      if (psel && !penable) begin
        if (prev_psel) proto_viol++;
        if (paddr == A_TSR && !pwrite && idle_run != GAP) gap_viol++;
        setups++;
        cur_w = pwrite; cur_a = paddr; cur_d = pwdata;
        acc_cycles = 0;
        prev_setup = 1'b1;
      end else if (psel && penable) begin
        if (!prev_psel) proto_viol++;
        if (pwrite !== cur_w || paddr !== cur_a || pwdata !== cur_d) proto_viol++;
        acc_cycles++;
        if (acc_cycles > wait_states) begin
          pready  = 1'b1;
          pslverr = (xfer_idx == slverr_idx);
          if (!pwrite) prdata = (tsr_q.size() > 0) ? tsr_q.pop_front() : 8'h00;
          obs_q.push_back({pwrite, paddr, pwrite ? pwdata : prdata});
          xfer_idx++;
          since_done   = 0;
          last_was_clr = pwrite && (paddr == A_TSR);
        end
      end else if (penable) begin
        proto_viol++;
      end
      idle_run  = psel ? 0 : idle_run + 1;
      prev_psel = psel;
    end
  end

  // ---------------------------------------------------------------- reference model
  // Expected bus traffic for one run, from the timer programming rules.
  task automatic build_expected(input logic [7:0] tdr, input logic dw,
                                input logic [1:0] clk, input logic os);
    bit done = 1'b0;
    int b = dw ? 1 : 0;
    logic [7:0] run_val;
    exp_q.delete();
    exp_ticks = 0;
    run_val = 8'h10 + (dw ? 8'h20 : 8'h00) + 8'(clk);
    exp_q.push_back({1'b1, A_TDR, tdr});
    exp_q.push_back({1'b1, A_TCR, 8'h80});
    exp_q.push_back({1'b1, A_TCR, run_val});
    foreach (resp_q[i]) begin
      if (!done) begin
        exp_q.push_back({1'b0, A_TSR, resp_q[i]});
        if (resp_q[i][b]) begin
          exp_q.push_back({1'b1, A_TSR, 8'h00});
          exp_ticks++;
          if (os) begin
            exp_q.push_back({1'b1, A_TCR, 8'h00});
            done = 1'b1;
          end
        end
      end
    end
    n_before_stop = exp_q.size();
    if (!done) exp_q.push_back({1'b1, A_TCR, 8'h00});
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic clear_sb();
    obs_q.delete(); tsr_q.delete();
    xfer_idx = 0; setups = 0; acc_cycles = 0; tick_cnt = 0;
    proto_viol = 0; gap_viol = 0; tick_viol = 0;
    wait_states = 0; slverr_idx = -1;
  endtask

  task automatic do_start(input logic [7:0] tdr, input logic dw,
                          input logic [1:0] clk, input logic os);
    @(negedge pclk);
    cfg_tdr = tdr; cfg_dw = dw; cfg_clk_sel = clk; one_shot = os;
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge pclk);
    stop = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge pclk);
    check($sformatf("%s_idle", name), busy, 1'b0);
  endtask

  task automatic wait_obs(input string name, input int n, input int budget);
    for (int i = 0; i < budget && obs_q.size() < n; i++) @(negedge pclk);
    check($sformatf("%s_progress", name), obs_q.size() >= n, 1'b1);
  endtask

  task automatic compare(input string name);
    check($sformatf("%s_len", name), obs_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < obs_q.size()) check($sformatf("%s_xfer%0d", name, i), obs_q[i], exp_q[i]);
    check($sformatf("%s_ticks", name), tick_cnt, exp_ticks);
    check($sformatf("%s_evt_cnt", name), evt_cnt, 8'(exp_ticks));
    check($sformatf("%s_err", name), err, 1'b0);
    check($sformatf("%s_proto", name), proto_viol, 0);
    check($sformatf("%s_gap", name), gap_viol, 0);
    check($sformatf("%s_tick_shape", name), tick_viol, 0);
  endtask

  // Full run: start, a stray start while busy, then either one-shot
  // completion or a stop once all scripted responses are consumed.
  task automatic run_scenario(input string name, input logic [7:0] tdr, input logic dw,
                              input logic [1:0] clk, input logic os, input int ws);
    clear_sb();
    wait_states = ws;
    tsr_q = resp_q;
    build_expected(tdr, dw, clk, os);
    do_start(tdr, dw, clk, os);
    check($sformatf("%s_busy_start", name), busy, 1'b1);
    check($sformatf("%s_err_start", name), err, 1'b0);
    repeat (4) @(negedge pclk);
    cfg_tdr = 8'($urandom); cfg_dw = ~dw; cfg_clk_sel = ~clk; one_shot = ~os;
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    if (!os) begin
      wait_obs(name, n_before_stop, 4000);
      @(negedge pclk);
      pulse_stop();
    end
    wait_idle(name, 4000);
    compare(name);
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] tdr, r;
    logic       dw, os;
    logic [1:0] clk;
    int         n, b;
    bit         found;

    // Reset values while presetn is held low.
    #12;
    check("rst_psel", psel, 1'b0);
    check("rst_penable", penable, 1'b0);
    check("rst_pwrite", pwrite, 1'b0);
    check("rst_paddr", paddr, 8'h00);
    check("rst_pwdata", pwdata, 8'h00);
    check("rst_tick", tick, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_evt_cnt", evt_cnt, 8'h00);
    @(negedge pclk);
    presetn = 1'b1;
    repeat (2) @(negedge pclk);
    clear_sb();

    // stop in IDLE does nothing.
    pulse_stop();
    repeat (3) @(negedge pclk);
    check("idle_stop_busy", busy, 1'b0);
    check("idle_stop_setups", setups, 0);

    // Basic programming sequence, three empty polls then an underflow.
    resp_q = '{8'h00, 8'h00, 8'h00, 8'h02};
    run_scenario("basic", 8'hFF, 1'b1, 2'd3, 1'b0, 0);

    // One-shot overflow mode.
    resp_q = '{8'h01};
    run_scenario("oneshot", 8'h5A, 1'b0, 2'd1, 1'b1, 0);

    // Counting up: bit 1 alone is not an event, both bits set is.
    resp_q = '{8'h02, 8'h03, 8'hFC};
    run_scenario("bothbits", 8'h10, 1'b0, 2'd2, 1'b0, 2);

    // Randomised runs.
    for (int k = 0; k < 6; k++) begin
      tdr = 8'($urandom);
      dw  = 1'($urandom_range(0, 1));
      clk = 2'($urandom_range(0, 3));
      os  = 1'($urandom_range(0, 1));
      n   = $urandom_range(1, 4);
      b   = dw ? 1 : 0;
      resp_q.delete();
      for (int j = 0; j < n; j++) begin
        r = 8'($urandom);
        if (os) r[b] = (j == n - 1);
        resp_q.push_back(r);
      end
      run_scenario($sformatf("rand%0d", k), tdr, dw, clk, os, $urandom_range(0, 4));
    end

    // pready never returns during the TDR write.
    clear_sb();
    wait_states = 100000;
    do_start(8'h33, 1'b0, 2'd0, 1'b0);
    wait_idle("tmo", 400);
    check("tmo_err", err, 1'b1);
    check("tmo_access_cycles", acc_cycles, TMO);
    check("tmo_xfers", obs_q.size(), 0);
    repeat (40) @(negedge pclk);
    check("tmo_setups", setups, 1);
    check("tmo_psel_quiet", psel, 1'b0);
    // The next start clears err.
    resp_q = '{8'h02};
    run_scenario("after_tmo", 8'hA5, 1'b1, 2'd0, 1'b1, 1);

    // Slave error on the TCR load write.
    clear_sb();
    slverr_idx = 1;
    do_start(8'h44, 1'b1, 2'd1, 1'b0);
    wait_idle("slverr", 400);
    repeat (30) @(negedge pclk);
    check("slverr_err", err, 1'b1);
    check("slverr_setups", setups, 2);
    check("slverr_len", obs_q.size(), 2);
    if (obs_q.size() >= 2) check("slverr_xfer1", obs_q[1], {1'b1, A_TCR, 8'h80});

    // stop during a slow TSR read: no flag, then with the flag set.
    for (int k = 0; k < 2; k++) begin
      clear_sb();
      wait_states = 5;
      resp_q = (k == 0) ? '{8'h00} : '{8'h02};
      tsr_q = resp_q;
      build_expected(8'h77, 1'b1, 2'd2, 1'b0);
      do_start(8'h77, 1'b1, 2'd2, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
        @(negedge pclk);
        found = psel && penable && (paddr == A_TSR) && !pwrite;
      end
      check($sformatf("stop%0d_found", k), found, 1'b1);
      pulse_stop();
      wait_idle($sformatf("stop%0d", k), 2000);
      compare($sformatf("stop%0d", k));
    end

    // Asynchronous reset in the middle of an ACCESS phase.
    clear_sb();
    wait_states = 3;
    tsr_q = '{8'h02};
    do_start(8'h12, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 2000 && tick_cnt == 0; i++) @(negedge pclk);
    check("arst_tick_seen", tick_cnt, 1);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge pclk);
      found = psel && penable;
    end
    check("arst_found", found, 1'b1);
    check("arst_evt_before", evt_cnt, 8'h01);
    #2 presetn = 1'b0;
    #1;
    check("arst_psel", psel, 1'b0);
    check("arst_penable", penable, 1'b0);
    check("arst_pwrite", pwrite, 1'b0);
    check("arst_paddr", paddr, 8'h00);
    check("arst_busy", busy, 1'b0);
    check("arst_evt_cnt", evt_cnt, 8'h00);
    check("arst_tick", tick, 1'b0);
    @(negedge pclk);
    presetn = 1'b1;
    repeat (3) @(negedge pclk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
